// File: rtl/arm7tdmi_cp_responder_if.sv
// Coprocessor handshake bundle between the core (master) and a coprocessor responder (slave).
interface arm7tdmi_cp_responder_if;
  logic        cp_req_valid;
  logic [2:0]  cp_op;
  logic [3:0]  cp_num;
  logic [3:0]  cp_opc1;
  logic [3:0]  cp_crd;
  logic [3:0]  cp_crn;
  logic [3:0]  cp_crm;
  logic [3:0]  cp_len;
  logic [31:0] cp_wdata;
  logic        cp_wvalid;
  logic        cp_rready;
  logic        cp_flush;
  logic        cp_absent;
  logic        cp_busy;
  logic        cp_accept;
  logic [31:0] cp_rdata;
  logic        cp_rvalid;
  logic        cp_done;

  modport master (
    output cp_req_valid, cp_op, cp_num, cp_opc1, cp_crd, cp_crn, cp_crm, cp_len,
    output cp_wdata, cp_wvalid, cp_rready, cp_flush,
    input  cp_absent, cp_busy, cp_accept, cp_rdata, cp_rvalid, cp_done
  );

  modport slave (
    input  cp_req_valid, cp_op, cp_num, cp_opc1, cp_crd, cp_crn, cp_crm, cp_len,
    input  cp_wdata, cp_wvalid, cp_rready, cp_flush,
    output cp_absent, cp_busy, cp_accept, cp_rdata, cp_rvalid, cp_done
  );
endinterface

// File: rtl/arm7tdmi_cp_responder.sv
// Generic coprocessor responder: claims CDP/LDC/STC/MRC/MCR for one coprocessor number,
// waits a programmable number of busy cycles, then executes against a 16 x 32-bit file.
module arm7tdmi_cp_responder #(
  parameter logic [3:0]  CP_NUM      = 4'd10,
  parameter int unsigned BUSY_CYCLES = 2
) (
  input logic                    clk,
  input logic                    rst_n,
  arm7tdmi_cp_responder_if.slave cp
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StBusy = 3'd1;
  localparam logic [2:0] StExec = 3'd2;
  localparam logic [2:0] StXin  = 3'd3;
  localparam logic [2:0] StXout = 3'd4;
  localparam logic [2:0] StDone = 3'd5;

  localparam logic [2:0] OpCdp = 3'b000;
  localparam logic [2:0] OpLdc = 3'b001;
  localparam logic [2:0] OpStc = 3'b010;
  localparam logic [2:0] OpMrc = 3'b100;
  localparam logic [2:0] OpMcr = 3'b110;

  localparam logic [3:0] BusyInit = 4'(BUSY_CYCLES);

  logic [2:0]  state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [3:0]  opc1_q, opc1_d;
  logic [3:0]  crd_q, crd_d;
  logic [3:0]  crn_q, crn_d;
  logic [3:0]  crm_q, crm_d;
  logic [3:0]  len_q, len_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  idx_q, idx_d;
  logic        absent_q, absent_d;
  logic [31:0] regs_q [16];
  logic [31:0] regs_d [16];

  logic        op_legal;
  logic        req_ok;
  logic        req_block;
  logic [31:0] opa, opb, alu;

  always_comb begin
    unique case (cp.cp_op)
      OpCdp:                      op_legal = (cp.cp_opc1 <= 4'd4);
      OpLdc, OpStc, OpMrc, OpMcr: op_legal = 1'b1;
      default:                    op_legal = 1'b0;
    endcase
    req_ok    = op_legal && (cp.cp_num == CP_NUM);
    req_block = (cp.cp_op == OpLdc) || (cp.cp_op == OpStc);
  end

  always_comb begin
    opa = regs_q[crn_q];
    opb = regs_q[crm_q];
    unique case (opc1_q)
      4'd0:    alu = opa + opb;
      4'd1:    alu = opa - opb;
      4'd2:    alu = opa & opb;
      4'd3:    alu = opa ^ opb;
      default: alu = opa;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    opc1_d   = opc1_q;
    crd_d    = crd_q;
    crn_d    = crn_q;
    crm_d    = crm_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    absent_d = 1'b0;
    regs_d   = regs_q;

    // Flush beats any transfer in the same cycle, so no write or advance happens.
    if (state_q != StIdle && cp.cp_flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cp.cp_req_valid) begin
            op_d   = cp.cp_op;
            opc1_d = cp.cp_opc1;
            crd_d  = cp.cp_crd;
            crn_d  = cp.cp_crn;
            crm_d  = cp.cp_crm;
            len_d  = cp.cp_len;
            idx_d  = req_block ? cp.cp_crd : cp.cp_crn;
            if (req_ok) begin
              state_d = StBusy;
              cnt_d   = BusyInit;
            end else begin
              absent_d = 1'b1;
            end
          end
        end
        StBusy: begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            // Reuse the counter as "words remaining minus one" for the transfer phase.
            cnt_d = ((op_q == OpLdc) || (op_q == OpStc)) ? len_q : 4'd0;
            unique case (op_q)
              OpCdp:        state_d = StExec;
              OpLdc, OpMcr: state_d = StXin;
              default:      state_d = StXout;
            endcase
          end
        end
        StExec: begin
          regs_d[crd_q] = alu;
          state_d       = StDone;
        end
        StXin: begin
          if (cp.cp_wvalid) begin
            regs_d[idx_q] = cp.cp_wdata;
            idx_d         = idx_q + 4'd1;
            if (cnt_q == 4'd0) state_d = StDone;
            else               cnt_d   = cnt_q - 4'd1;
          end
        end
        StXout: begin
          if (cp.cp_rready) begin
            idx_d = idx_q + 4'd1;
            if (cnt_q == 4'd0) state_d = StDone;
            else               cnt_d   = cnt_q - 4'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      op_q     <= 3'd0;
      opc1_q   <= 4'd0;
      crd_q    <= 4'd0;
      crn_q    <= 4'd0;
      crm_q    <= 4'd0;
      len_q    <= 4'd0;
      cnt_q    <= 4'd0;
      idx_q    <= 4'd0;
      absent_q <= 1'b0;
      for (int i = 0; i < 16; i++) regs_q[i] <= 32'd0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      opc1_q   <= opc1_d;
      crd_q    <= crd_d;
      crn_q    <= crn_d;
      crm_q    <= crm_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      absent_q <= absent_d;
      regs_q   <= regs_d;
    end
  end

  assign cp.cp_absent = absent_q;
  assign cp.cp_busy   = (state_q == StBusy) && (cnt_q != 4'd0);
  assign cp.cp_accept = (state_q == StBusy) && (cnt_q == 4'd0);
  assign cp.cp_rvalid = (state_q == StXout);
  assign cp.cp_rdata  = (state_q == StXout) ? regs_q[idx_q] : 32'd0;
  assign cp.cp_done   = (state_q == StDone);

endmodule

// File: tb/tb_arm7tdmi_cp_responder.sv
// Directed plus randomized bench for arm7tdmi_cp_responder against a register-array model.
module tb_arm7tdmi_cp_responder;

  localparam logic [2:0] CDP = 3'b000, LDC = 3'b001, STC = 3'b010, MRC = 3'b100, MCR = 3'b110;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  arm7tdmi_cp_responder_if cpif ();
  arm7tdmi_cp_responder_if if0 ();

  arm7tdmi_cp_responder #(.CP_NUM(4'd10), .BUSY_CYCLES(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .cp   (cpif.slave)
  );

  arm7tdmi_cp_responder #(.CP_NUM(4'd10), .BUSY_CYCLES(0)) dut0 (
    .clk  (clk),
    .rst_n(rst_n),
    .cp   (if0.slave)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] model [16];
  logic [31:0] fixed_q [$];
  logic [31:0] last_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_absent"}, cpif.cp_absent, 0);
    chk({tag, "_busy"}, cpif.cp_busy, 0);
    chk({tag, "_accept"}, cpif.cp_accept, 0);
    chk({tag, "_rvalid"}, cpif.cp_rvalid, 0);
    chk({tag, "_rdata"}, cpif.cp_rdata, 0);
    chk({tag, "_done"}, cpif.cp_done, 0);
  endtask

  // Flush or reset at the current negedge while a transfer is also offered.
  task automatic abort_now(input bit by_reset);
    cpif.cp_wvalid = 1'b1;
    cpif.cp_wdata  = 32'hBAD0BAD0;
    cpif.cp_rready = 1'b1;
    if (by_reset) rst_n = 1'b0;
    else cpif.cp_flush = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    cpif.cp_flush  = 1'b0;
    cpif.cp_wvalid = 1'b0;
    cpif.cp_rready = 1'b0;
    if (by_reset) for (int i = 0; i < 16; i++) model[i] = 32'd0;
    chk_quiet(by_reset ? "reset_abort" : "flush_abort");
    @(negedge clk);
    chk("abort_no_done", cpif.cp_done, 0);
  endtask

  task automatic do_instr(input logic [2:0] op, input logic [3:0] num, input logic [3:0] opc1,
                          input logic [3:0] crd, input logic [3:0] crn, input logic [3:0] crm,
                          input logic [3:0] len, input int abort_at, input bit by_reset);
    bit rej, go, first;
    int n, cnt, guard;
    logic [3:0] idx;
    logic [31:0] w, a, b, res;
    rej = (num != 4'd10) || !(op inside {CDP, LDC, STC, MRC, MCR}) || (op == CDP && opc1 > 4);
    n   = (op == LDC || op == STC) ? int'(len) + 1 : 1;
    idx = (op == LDC || op == STC) ? crd : crn;
    @(negedge clk);
    cpif.cp_req_valid = 1'b1;
    cpif.cp_op = op; cpif.cp_num = num; cpif.cp_opc1 = opc1;
    cpif.cp_crd = crd; cpif.cp_crn = crn; cpif.cp_crm = crm; cpif.cp_len = len;
    @(negedge clk);
    cpif.cp_req_valid = 1'b0;
    if (rej) begin
      chk("absent", cpif.cp_absent, 1);
      chk("absent_nobusy", cpif.cp_busy, 0);
      chk("absent_noaccept", cpif.cp_accept, 0);
      @(negedge clk);
      chk("absent_pulse", cpif.cp_absent, 0);
      chk("absent_nobusy2", cpif.cp_busy, 0);
      return;
    end
    chk("no_absent", cpif.cp_absent, 0);
    for (int k = 0; k < 2; k++) begin
      chk("busy", cpif.cp_busy, 1);
      chk("busy_noaccept", cpif.cp_accept, 0);
      @(negedge clk);
    end
    chk("accept", cpif.cp_accept, 1);
    chk("accept_nobusy", cpif.cp_busy, 0);
    @(negedge clk);
    chk("accept_pulse", cpif.cp_accept, 0);
    cnt = 0; guard = 0; first = 1'b1;
    if (op == CDP) begin
      a = model[crn]; b = model[crm];
      case (opc1)
        4'd0: res = a + b;
        4'd1: res = a - b;
        4'd2: res = a & b;
        4'd3: res = a ^ b;
        default: res = a;
      endcase
      chk("exec_no_done", cpif.cp_done, 0);
      @(negedge clk);
      model[crd] = res;
    end else if (op == LDC || op == MCR) begin
      while (cnt < n && guard < 200) begin
        guard++;
        chk("xin_no_done", cpif.cp_done, 0);
        if (cnt == abort_at) begin abort_now(by_reset); return; end
        go = ($urandom_range(0, 2) != 0);
        w  = (go && fixed_q.size() > 0) ? fixed_q.pop_front() : $urandom;
        cpif.cp_wvalid = go; cpif.cp_wdata = w;
        @(negedge clk);
        if (go) begin model[idx] = w; idx++; cnt++; end
      end
      cpif.cp_wvalid = 1'b0;
      chk("xin_count", cnt, n);
    end else begin
      while (cnt < n && guard < 200) begin
        guard++;
        chk("xout_rvalid", cpif.cp_rvalid, 1);
        chk("xout_rdata", cpif.cp_rdata, model[idx]);
        if (first) begin last_rd = cpif.cp_rdata; first = 1'b0; end
        if (cnt == abort_at) begin abort_now(by_reset); return; end
        go = ($urandom_range(0, 1) != 0);
        cpif.cp_rready = go;
        @(negedge clk);
        if (go) begin idx++; cnt++; end
      end
      cpif.cp_rready = 1'b0;
      chk("xout_count", cnt, n);
      chk("xout_rvalid_end", cpif.cp_rvalid, 0);
    end
    chk("done", cpif.cp_done, 1);
    @(negedge clk);
    chk("done_pulse", cpif.cp_done, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [2:0] legal [5];
    logic [2:0] op;
    int r;
    legal = '{CDP, LDC, STC, MRC, MCR};
    for (int i = 0; i < 16; i++) model[i] = 32'd0;
    cpif.cp_req_valid = 0; cpif.cp_op = 0; cpif.cp_num = 0; cpif.cp_opc1 = 0;
    cpif.cp_crd = 0; cpif.cp_crn = 0; cpif.cp_crm = 0; cpif.cp_len = 0;
    cpif.cp_wdata = 0; cpif.cp_wvalid = 0; cpif.cp_rready = 0; cpif.cp_flush = 0;
    if0.cp_req_valid = 0; if0.cp_op = 0; if0.cp_num = 0; if0.cp_opc1 = 0;
    if0.cp_crd = 0; if0.cp_crn = 0; if0.cp_crm = 0; if0.cp_len = 0;
    if0.cp_wdata = 0; if0.cp_wvalid = 0; if0.cp_rready = 0; if0.cp_flush = 0;

    repeat (3) @(negedge clk);
    chk_quiet("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_quiet("post_reset");

    fixed_q.push_back(32'hDEADBEEF);
    do_instr(MCR, 4'd10, 0, 0, 4'd3, 0, 0, -1, 0);
    do_instr(MRC, 4'd10, 0, 0, 4'd3, 0, 0, -1, 0);
    chk("mrc_deadbeef", last_rd, 32'hDEADBEEF);

    do_instr(MCR, 4'd5, 0, 0, 4'd3, 0, 0, -1, 0);
    do_instr(3'b011, 4'd10, 0, 0, 4'd3, 0, 0, -1, 0);
    do_instr(MRC, 4'd10, 0, 0, 4'd3, 0, 0, -1, 0);
    chk("absent_kept_reg", last_rd, 32'hDEADBEEF);

    fixed_q.push_back(32'h7FFFFFFF);
    do_instr(MCR, 4'd10, 0, 0, 4'd1, 0, 0, -1, 0);
    fixed_q.push_back(32'h1);
    do_instr(MCR, 4'd10, 0, 0, 4'd2, 0, 0, -1, 0);
    do_instr(CDP, 4'd10, 4'd0, 4'd4, 4'd1, 4'd2, 0, -1, 0);
    do_instr(MRC, 4'd10, 0, 0, 4'd4, 0, 0, -1, 0);
    chk("cdp_add_wrap", last_rd, 32'h80000000);
    fixed_q.push_back(32'h0);
    do_instr(MCR, 4'd10, 0, 0, 4'd5, 0, 0, -1, 0);
    fixed_q.push_back(32'h1);
    do_instr(MCR, 4'd10, 0, 0, 4'd6, 0, 0, -1, 0);
    do_instr(CDP, 4'd10, 4'd1, 4'd7, 4'd5, 4'd6, 0, -1, 0);
    do_instr(MRC, 4'd10, 0, 0, 4'd7, 0, 0, -1, 0);
    chk("cdp_sub_borrow", last_rd, 32'hFFFFFFFF);
    do_instr(CDP, 4'd10, 4'd7, 4'd7, 4'd5, 4'd6, 0, -1, 0);

    fixed_q = '{32'hA, 32'hB, 32'hC, 32'hD};
    do_instr(LDC, 4'd10, 0, 4'd14, 0, 0, 4'd3, -1, 0);
    do_instr(STC, 4'd10, 0, 4'd14, 0, 0, 4'd3, -1, 0);
    chk("stc_first_word", last_rd, 32'hA);

    fixed_q = '{32'h11, 32'h22, 32'h33, 32'h44};
    do_instr(LDC, 4'd10, 0, 4'd14, 0, 0, 4'd3, 2, 0);
    fixed_q.delete();
    do_instr(MRC, 4'd10, 0, 0, 4'd15, 0, 0, -1, 0);
    chk("flush_kept_c15", last_rd, 32'h22);
    do_instr(MRC, 4'd10, 0, 0, 4'd0, 0, 0, -1, 0);
    chk("flush_untouched_c0", last_rd, 32'hC);

    for (int t = 0; t < 80; t++) begin
      r  = $urandom_range(0, 19);
      op = (r < 18) ? legal[r % 5] : ((r == 18) ? 3'b011 : 3'b111);
      do_instr(op, ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'd10, 4'($urandom_range(0, 5)),
               4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), -1, 0);
    end

    do_instr(STC, 4'd10, 0, 4'd0, 0, 0, 4'd3, 1, 1);
    do_instr(MRC, 4'd10, 0, 0, 4'd5, 0, 0, -1, 0);
    chk("post_reset_mrc", last_rd, 32'h0);

    @(negedge clk);
    if0.cp_req_valid = 1'b1; if0.cp_op = MCR; if0.cp_num = 4'd10; if0.cp_crn = 4'd2;
    @(negedge clk);
    if0.cp_req_valid = 1'b0;
    chk("b0_accept", if0.cp_accept, 1);
    chk("b0_nobusy", if0.cp_busy, 0);
    @(negedge clk);
    if0.cp_wvalid = 1'b1; if0.cp_wdata = 32'h55;
    @(negedge clk);
    if0.cp_wvalid = 1'b0;
    chk("b0_mcr_done", if0.cp_done, 1);
    @(negedge clk);
    if0.cp_req_valid = 1'b1; if0.cp_op = MRC;
    @(negedge clk);
    if0.cp_req_valid = 1'b0;
    chk("b0_mrc_accept", if0.cp_accept, 1);
    chk("b0_mrc_nobusy", if0.cp_busy, 0);
    @(negedge clk);
    chk("b0_rvalid", if0.cp_rvalid, 1);
    chk("b0_rdata", if0.cp_rdata, 32'h55);
    if0.cp_rready = 1'b1;
    @(negedge clk);
    if0.cp_rready = 1'b0;
    chk("b0_mrc_done", if0.cp_done, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arm7tdmi_cp_responder.md
Name: arm7tdmi_cp_responder

Overview:
- Generic coprocessor slave on the core's coprocessor interface; it is the responder end of the CDP/LDC/STC/MRC/MCR handshake the core issues.
- Decodes an offered instruction and claims it or signals absent.
- Inserts programmable busy-wait cycles, then executes against a 16 x 32-bit coprocessor register file (c0..c15).
- Exchanges data words with the core through valid/ready transfers.

Parameters:
- CP_NUM, 4'd10: coprocessor number this instance answers to.
- BUSY_CYCLES, 2: busy-wait cycles before accept; legal range 0..15.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- cp_req_valid  in  1  instruction offered; fields held stable until cp_accept or cp_absent
- cp_op  in  3  operation code: CDP=000, LDC=001, STC=010, MRC=100, MCR=110
- cp_num  in  4  target coprocessor number
- cp_opc1  in  4  CDP opcode
- cp_crd  in  4  CDP destination / LDC-STC start register
- cp_crn  in  4  CDP operand A / MRC-MCR register
- cp_crm  in  4  CDP operand B
- cp_len  in  4  LDC/STC word count minus 1
- cp_wdata  in  32  write word (MCR/LDC)
- cp_wvalid  in  1  cp_wdata valid
- cp_rready  in  1  core accepts cp_rdata
- cp_flush  in  1  abandon current instruction
- cp_absent  out  1  one-cycle pulse: instruction not handled
- cp_busy  out  1  busy-wait in progress
- cp_accept  out  1  one-cycle pulse: instruction claimed
- cp_rdata  out  32  read word (MRC/STC)
- cp_rvalid  out  1  cp_rdata valid
- cp_done  out  1  one-cycle pulse: instruction complete

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low, on rst_n.
- Reset: all outputs 0, all registers 0, state IDLE. Reset wins over every other input in the same cycle, including mid-transfer.
- States: IDLE, BUSY, EXEC, XIN, XOUT, DONE.
- IDLE: cp_req_valid is sampled only in IDLE; requests in any other state are ignored. On cycle T with cp_req_valid, latch all fields, then decode:
  - Reject if cp_num!=CP_NUM, cp_op is not one of the 5 codes, or CDP has cp_opc1>4.
  - On reject: cp_absent=1 at T+1, then stay in IDLE. No busy, no accept, no register change.
  - Otherwise go to BUSY with counter=BUSY_CYCLES.
- BUSY: cp_busy=1 for exactly BUSY_CYCLES cycles (T+1..T+B). cp_accept=1 at T+1+B with cp_busy=0. With B=0, accept is at T+1. In the accept cycle, move to EXEC (CDP), XIN (LDC/MCR) or XOUT (STC/MRC).
- EXEC: single cycle. Writes crd = f(crn,crm), then DONE. Arithmetic is modulo 2^32; carry and borrow are discarded.
  - opc1 0: add
  - opc1 1: sub (crn-crm)
  - opc1 2: and
  - opc1 3: xor
  - opc1 4: move crn
- Word count: N = cp_len+1 (1..16) for LDC/STC; N = 1 for MRC/MCR.
- XIN: each cycle with cp_wvalid=1 writes cp_wdata to the current index and advances.
  - Index starts at crd (LDC) or crn (MCR) and wraps 15->0.
  - After the Nth word, go to DONE. cp_wvalid=0 cycles stall with no write.
- XOUT: cp_rvalid=1 with cp_rdata = reg[index], starting at crd (STC) or crn (MRC), wrapping 15->0.
  - A word transfers when cp_rvalid&&cp_rready. The index then advances and the next word appears the following cycle.
  - cp_rdata is stable while cp_rready=0. After the Nth transfer, cp_rvalid=0 and the state goes to DONE.
- DONE: cp_done=1 for one cycle, then IDLE. The earliest next request is sampled in the cycle after DONE.
- cp_flush: takes effect in any non-IDLE state.
  - Next cycle: IDLE, all handshake outputs 0, no cp_done.
  - Writes already performed are kept. No write occurs in the flush cycle.
- Simultaneous events: cp_flush outranks cp_wvalid and cp_rready in the same cycle, so no transfer occurs.

Test Plan:
- MCR, CP10, crn=3, wdata=0xDEADBEEF, B=2: cp_busy at T+1..T+2, cp_accept at T+3, cp_done after the write. Then MRC crn=3 -> cp_rdata=0xDEADBEEF, cp_rvalid until cp_rready.
- cp_num=5 (or cp_op=011): cp_absent pulse at T+1. No busy, no accept. Registers unchanged.
- CDP add with c1=0x7FFFFFFF, c2=1, crd=4 -> c4=0x80000000. CDP sub with c5=0, c6=1 -> crd=0xFFFFFFFF. opc1=7 -> absent.
- LDC crd=14, len=3, words 0xA/0xB/0xC/0xD with cp_wvalid gaps -> c14, c15, c0, c1 loaded. STC of the same range with cp_rready toggling -> same order, data held during stalls, exactly 4 transfers, then cp_done.
- cp_flush after 2 of 4 LDC words -> only c14 and c15 written, IDLE next cycle, no cp_done. A new MRC is then accepted normally.
- rst_n=0 during STC XOUT -> all outputs 0 next cycle, registers cleared, a subsequent MRC returns 0.
- BUSY_CYCLES=0 build: accept at T+1, no cp_busy assertion.
